// File: rtl/amiq_fifo_status_pkg.sv
// Shared types and helpers for the FIFO status generator: level width function,
// packed status-flag struct and its reset value.
package amiq_fifo_status_pkg;

    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic alm_full;
        logic full;
        logic alm_empty;
        logic empty;
    } status_t;

    localparam status_t STATUS_RST = '{alm_full: 1'b0, full: 1'b0, alm_empty: 1'b1, empty: 1'b1};

endpackage

// File: rtl/amiq_fifo_level_cnt.sv
// FIFO fill-level counter: integrates accepted push/pop strobes and exposes both the
// registered level and the next-cycle level that the status flags are derived from.
module amiq_fifo_level_cnt #(
    parameter int LVL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_ok,
    input  logic             pop_ok,
    output logic [LVL_W-1:0] level,
    output logic [LVL_W-1:0] level_nxt
);

    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;

    // Accepted strobes can never push past DEPTH or below zero, so no saturation is needed.
    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level     = level_q;
    assign level_nxt = level_d;

endmodule

// File: rtl/amiq_fifo_status_gen.sv
// FIFO status generator: accept logic, registered full/almost/empty flags and sticky
// overflow/underflow errors. Define AMIQ_FIFO_STATUS_PEAK_EN to build the peak-level tracker.
module amiq_fifo_status_gen
    import amiq_fifo_status_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LVL_W = lvl_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [LVL_W-1:0] alm_full_thresh,
    input  logic [LVL_W-1:0] alm_empty_thresh,
    input  logic             err_clr,
    output logic             push_ok,
    output logic             pop_ok,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             alm_full,
    output logic             empty,
    output logic             alm_empty,
    output logic             ovf,
    output logic             udf,
    output logic [LVL_W-1:0] peak_level
);

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    status_t          status_q;
    status_t          status_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             udf_q;
    logic             udf_d;
    logic [LVL_W-1:0] level_nxt;
    logic [LVL_W-1:0] af_thresh_sat;
    logic [LVL_W:0]   af_limit;

    assign pop_ok  = pop & ~status_q.empty;
    assign push_ok = push & (~status_q.full | pop_ok);

    amiq_fifo_level_cnt #(
        .LVL_W(LVL_W)
    ) u_level_cnt (
        .clk      (clk),
        .rst      (rst),
        .push_ok  (push_ok),
        .pop_ok   (pop_ok),
        .level    (level),
        .level_nxt(level_nxt)
    );

    // One extra bit keeps DEPTH - thresh from wrapping when the threshold exceeds DEPTH.
    always_comb begin
        af_thresh_sat      = (alm_full_thresh > DEPTH_L) ? DEPTH_L : alm_full_thresh;
        af_limit           = {1'b0, DEPTH_L} - {1'b0, af_thresh_sat};
        status_d           = STATUS_RST;
        status_d.full      = (level_nxt == DEPTH_L);
        status_d.empty     = (level_nxt == '0);
        status_d.alm_full  = ({1'b0, level_nxt} >= af_limit);
        status_d.alm_empty = (level_nxt <= alm_empty_thresh);
        ovf_d              = (push & ~push_ok) | (ovf_q & ~err_clr);
        udf_d              = (pop & ~pop_ok) | (udf_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= STATUS_RST;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign full      = status_q.full;
    assign alm_full  = status_q.alm_full;
    assign empty     = status_q.empty;
    assign alm_empty = status_q.alm_empty;
    assign ovf       = ovf_q;
    assign udf       = udf_q;

`ifdef AMIQ_FIFO_STATUS_PEAK_EN
    logic [LVL_W-1:0] peak_q;
    logic [LVL_W-1:0] peak_d;

    always_comb begin
        peak_d = peak_q;
        if (err_clr) begin
            peak_d = level_nxt;
        end else if (level_nxt > peak_q) begin
            peak_d = level_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_level = peak_q;
`else
    assign peak_level = '0;
`endif

endmodule

// File: tb/tb_amiq_fifo_status_gen.sv
// Self-checking bench for amiq_fifo_status_gen: directed scenarios plus a randomized run,
// all compared against an occupancy-count reference model.
module tb_amiq_fifo_status_gen;

    localparam int DEPTH = 16;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int VW    = 2 * LVL_W + 6;
`ifdef AMIQ_FIFO_STATUS_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic             err_clr;
    logic [LVL_W-1:0] af_t;
    logic [LVL_W-1:0] ae_t;
    logic             push_ok;
    logic             pop_ok;
    logic [LVL_W-1:0] level;
    logic             full;
    logic             alm_full;
    logic             empty;
    logic             alm_empty;
    logic             ovf;
    logic             udf;
    logic [LVL_W-1:0] peak_level;
    logic [VW-1:0]    obs_vec;

    int total = 0;
    int bad   = 0;

    int m_level;
    int m_peak;
    bit m_ovf;
    bit m_udf;
    bit e_push_ok;
    bit e_pop_ok;
    logic o_push_ok;
    logic o_pop_ok;

    amiq_fifo_status_gen #(
        .DEPTH(DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .push            (push),
        .pop             (pop),
        .alm_full_thresh (af_t),
        .alm_empty_thresh(ae_t),
        .err_clr         (err_clr),
        .push_ok         (push_ok),
        .pop_ok          (pop_ok),
        .level           (level),
        .full            (full),
        .alm_full        (alm_full),
        .empty           (empty),
        .alm_empty       (alm_empty),
        .ovf             (ovf),
        .udf             (udf),
        .peak_level      (peak_level)
    );

    assign obs_vec = {level, full, alm_full, empty, alm_empty, ovf, udf, peak_level};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected registered outputs derived from the occupancy count and the threshold rules.
    function automatic logic [VW-1:0] exp_vec();
        int af_lim;
        int pk;
        af_lim = DEPTH - ((int'(af_t) > DEPTH) ? DEPTH : int'(af_t));
        pk     = PEAK_EN ? m_peak : 0;
        return {LVL_W'(m_level), m_level == DEPTH, m_level >= af_lim, m_level == 0,
                m_level <= int'(ae_t), m_ovf, m_udf, LVL_W'(pk)};
    endfunction

    task automatic model_reset();
        m_level = 0;
        m_peak  = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drives one clock of strobes, captures comb accept outputs, advances the model.
    task automatic cycle(input bit p, input bit q, input bit c);
        push    = p;
        pop     = q;
        err_clr = c;
        #1;
        e_pop_ok  = q && (m_level > 0);
        e_push_ok = p && ((m_level < DEPTH) || e_pop_ok);
        o_push_ok = push_ok;
        o_pop_ok  = pop_ok;
        @(posedge clk);
        m_level = m_level + int'(e_push_ok) - int'(e_pop_ok);
        m_ovf   = (p && !e_push_ok) || (m_ovf && !c);
        m_udf   = (q && !e_pop_ok) || (m_udf && !c);
        if (c) m_peak = m_level;
        else if (m_level > m_peak) m_peak = m_level;
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        af_t = LVL_W'(2);
        ae_t = LVL_W'(3);
        do_reset();
        total++;
        if (obs_vec !== exp_vec()) begin
            bad++;
            $display("[TB] FAIL reset_state: got %h want %h", obs_vec, exp_vec());
        end
        cycle(1'b0, 1'b0, 1'b0);
        total++;
        if (obs_vec !== exp_vec()) begin
            bad++;
            $display("[TB] FAIL reset_idle: got %h want %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL fill_%0d: got %h want %h", i, obs_vec, exp_vec());
            end
            if (i == 4) begin
                total++;
                if (alm_empty !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL alm_empty_after_4: got %b want 0", alm_empty);
                end
            end
            if (i == 14) begin
                total++;
                if (alm_full !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL alm_full_after_14: got %b want 1", alm_full);
                end
            end
        end
        total++;
        if (full !== 1'b1 || level !== LVL_W'(DEPTH)) begin
            bad++;
            $display("[TB] FAIL full_after_16: got full=%b level=%0d want 1/16", full, level);
        end
    endtask

    task automatic test_overflow();
        cycle(1'b1, 1'b0, 1'b0);
        total++;
        if (o_push_ok !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ovf_push_ok: got %b want 0", o_push_ok);
        end
        total++;
        if (obs_vec !== exp_vec() || ovf !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ovf_set: got %h want %h", obs_vec, exp_vec());
        end
        cycle(1'b0, 1'b0, 1'b1);
        total++;
        if (obs_vec !== exp_vec() || ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ovf_clr: got %h want %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_full_push_pop();
        cycle(1'b1, 1'b1, 1'b0);
        total++;
        if ({o_push_ok, o_pop_ok} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL full_pp_accept: got %b%b want 11", o_push_ok, o_pop_ok);
        end
        total++;
        if (obs_vec !== exp_vec() || level !== LVL_W'(DEPTH) || full !== 1'b1 || ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_pp_state: got %h want %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_empty_push_pop();
        do_reset();
        cycle(1'b1, 1'b1, 1'b0);
        total++;
        if ({o_push_ok, o_pop_ok} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL empty_pp_accept: got %b%b want 10", o_push_ok, o_pop_ok);
        end
        total++;
        if (obs_vec !== exp_vec() || level !== LVL_W'(1) || empty !== 1'b0 || udf !== 1'b1) begin
            bad++;
            $display("[TB] FAIL empty_pp_state: got %h want %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_err_clr_collision();
        do_reset();
        cycle(1'b0, 1'b1, 1'b1);
        total++;
        if (obs_vec !== exp_vec() || udf !== 1'b1) begin
            bad++;
            $display("[TB] FAIL clr_vs_udf: got %h want %h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (9) cycle(1'b1, 1'b0, 1'b0);
        total++;
        if (level !== LVL_W'(9)) begin
            bad++;
            $display("[TB] FAIL pre_rst_level: got %0d want 9", level);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (obs_vec !== exp_vec()) begin
            bad++;
            $display("[TB] FAIL async_rst: got %h want %h", obs_vec, exp_vec());
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_peak();
        do_reset();
        repeat (12) cycle(1'b1, 1'b0, 1'b0);
        repeat (7) cycle(1'b0, 1'b1, 1'b0);
        total++;
        if (peak_level !== (PEAK_EN ? LVL_W'(12) : LVL_W'(0)) || level !== LVL_W'(5)) begin
            bad++;
            $display("[TB] FAIL peak_level: got peak=%0d level=%0d want %0d/5",
                     peak_level, level, PEAK_EN ? 12 : 0);
        end
    endtask

    task automatic test_random();
        int push_pct;
        do_reset();
        push_pct = 50;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) push_pct = int'($urandom_range(15, 85));
            if (i % 40 == 0) begin
                af_t = LVL_W'($urandom_range(0, 20));
                ae_t = LVL_W'($urandom_range(0, 20));
            end
            cycle($urandom_range(0, 99) < push_pct, $urandom_range(0, 99) < (100 - push_pct),
                  $urandom_range(0, 19) == 0);
            total++;
            if ({o_push_ok, o_pop_ok} !== {e_push_ok, e_pop_ok}) begin
                bad++;
                $display("[TB] FAIL rnd_accept_%0d: got %b%b want %b%b", i, o_push_ok, o_pop_ok,
                         e_push_ok, e_pop_ok);
            end
            total++;
            if (obs_vec !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL rnd_state_%0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
        af_t    = LVL_W'(2);
        ae_t    = LVL_W'(3);
        test_reset();
        test_fill();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_err_clr_collision();
        test_async_reset();
        test_peak();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
